// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Single-outstanding-request instruction fetch stage. Issues word reads to
//   instruction memory, holds one fetched instruction for decode, and handles
//   redirects. A redirect can arrive while a read is still in flight. In that
//   case the read is allowed to complete and its data is dropped.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req/addr       memory read request and its byte address
//   imem_ack/rdata      read completion and the returned word
//   instr, pc_out,      held instruction, its address and the link value
//   pc_plus4
//   instr_valid         held outputs are valid for decode
//   decode_ready        decode consumes the held instruction this cycle
//   redirect/_pc        restart fetch at redirect_pc (low two bits ignored)
// -----------------------------------------------------------------------------
module fetch_unit (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        decode_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] drain_addr;   // address of the abandoned in-flight read
   logic [31:0] redir_aligned;
   logic        capture;

   assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;
   assign capture       = (state == REQ) && imem_ack && !redirect;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = REQ;
         REQ: begin
            if (redirect)      state_nxt = imem_ack ? REQ : DRAIN;
            else if (imem_ack) state_nxt = HOLD;
         end
         HOLD:    if (redirect || decode_ready) state_nxt = REQ;
         DRAIN:   if (imem_ack) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: the request is masked while reset is applied
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = 32'h0;
      if (!rst) begin
         imem_req  = (state == REQ) || (state == DRAIN);
         imem_addr = (state == DRAIN) ? drain_addr : pc;
      end
   end

   // datapath: fetch PC, abandoned address, held instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= 32'h0;
         drain_addr  <= 32'h0;
         instr       <= 32'h0;
         pc_out      <= 32'h0;
         pc_plus4    <= 32'h0;
         instr_valid <= 1'b0;
      end else begin
         // Redirect wins in every state; the latest one in DRAIN overwrites pc.
         if (redirect)     pc <= redir_aligned;
         else if (capture) pc <= pc + 32'd4;

         // The read stays on the bus at its original address until acked.
         if ((state == REQ) && redirect && !imem_ack) drain_addr <= pc;

         if (capture) begin
            instr       <= imem_rdata;
            pc_out      <= pc;
            pc_plus4    <= pc + 32'd4;
            instr_valid <= 1'b1;
         end else if ((state == HOLD) && (redirect || decode_ready)) begin
            instr_valid <= 1'b0;
         end
      end
   end

endmodule
